// File: rtl/pixel_normalizer_if.sv
// AXI-Stream style pixel channel used on both sides of pixel_normalizer.
interface pixel_normalizer_if #(
    parameter int DATA_W = 10
) ();
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;

    modport master (output tvalid, output tdata, output tlast, input  tready);
    modport slave  (input  tvalid, input  tdata, input  tlast, output tready);
endinterface

// File: rtl/pixel_normalizer.sv
// Frame-level pixel normaliser: scales each pixel by a latched Q1.FRAC_W coefficient,
// rounds half up, saturates, and streams out with a generated tlast under HLS-style control.
module pixel_normalizer #(
    parameter int PIXEL_W = 10,
    parameter int FRAC_W  = 8,
    parameter int CNT_W   = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ap_start,
    input  logic                upstream_done,
    input  logic [CNT_W-1:0]    num_pixels,
    input  logic [FRAC_W:0]     norm_coef,
    output logic                ap_ready,
    output logic                ap_idle,
    output logic                ap_done,
    output logic                sat_seen,
    output logic                tlast_err,
    pixel_normalizer_if.slave   s_axis,
    pixel_normalizer_if.master  m_axis
);
    localparam int PROD_W = PIXEL_W + FRAC_W + 1;
    localparam int RND_W  = PROD_W + 1 - FRAC_W;
    localparam logic [PROD_W:0] HALF = {{(PROD_W - FRAC_W + 1){1'b0}}, 1'b1, {(FRAC_W - 1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_UP,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    npix;
    logic [CNT_W-1:0]    in_cnt;
    logic [CNT_W-1:0]    out_cnt;
    logic [FRAC_W:0]     coef;

    logic                v1;
    logic                last1;
    logic [PROD_W-1:0]   prod1;
    logic                v2;
    logic                last2;
    logic [PIXEL_W-1:0]  data2;

    logic                adv;
    logic                in_hs;
    logic                out_hs;
    logic                in_last;
    logic                sat;
    logic [PROD_W-1:0]   prod;
    logic [RND_W-1:0]    rnd;
    logic [PIXEL_W-1:0]  res;

    always_comb begin
        adv           = !v2 || m_axis.tready;
        s_axis.tready = (state == S_RUN) && adv && (in_cnt < npix);
        in_hs         = s_axis.tready && s_axis.tvalid;
        out_hs        = v2 && m_axis.tready;
        in_last       = (in_cnt == npix - CNT_W'(1));
        prod          = PROD_W'(s_axis.tdata) * PROD_W'(coef);
        rnd           = RND_W'(({1'b0, prod1} + HALF) >> FRAC_W);
        sat           = rnd > RND_W'({PIXEL_W{1'b1}});
        res           = sat ? '1 : rnd[PIXEL_W-1:0];
    end

    assign m_axis.tvalid = v2;
    assign m_axis.tdata  = data2;
    assign m_axis.tlast  = last2;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            ap_idle   <= 1'b1;
            ap_ready  <= 1'b0;
            ap_done   <= 1'b0;
            sat_seen  <= 1'b0;
            tlast_err <= 1'b0;
            npix      <= '0;
            coef      <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            v1        <= 1'b0;
            last1     <= 1'b0;
            prod1     <= '0;
            v2        <= 1'b0;
            last2     <= 1'b0;
            data2     <= '0;
        end else begin
            ap_ready <= 1'b0;
            ap_done  <= 1'b0;

            // Both stages move together; stage 2 clears its data when it receives a bubble.
            if (adv) begin
                v1    <= in_hs;
                last1 <= in_hs && in_last;
                prod1 <= prod;
                v2    <= v1;
                last2 <= v1 && last1;
                data2 <= v1 ? res : '0;
                if (v1 && sat)
                    sat_seen <= 1'b1;
            end

            if (in_hs) begin
                in_cnt <= in_cnt + CNT_W'(1);
                if (s_axis.tlast != in_last)
                    tlast_err <= 1'b1;
            end
            if (out_hs)
                out_cnt <= out_cnt + CNT_W'(1);

            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        npix      <= num_pixels;
                        coef      <= norm_coef;
                        in_cnt    <= '0;
                        out_cnt   <= '0;
                        sat_seen  <= 1'b0;
                        tlast_err <= 1'b0;
                        ap_ready  <= 1'b1;
                        ap_idle   <= 1'b0;
                        if (!upstream_done) begin
                            state <= S_WAIT_UP;
                        end else if (num_pixels == '0) begin
                            state   <= S_DONE;
                            ap_done <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_WAIT_UP: begin
                    if (upstream_done) begin
                        if (npix == '0) begin
                            state   <= S_DONE;
                            ap_done <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (in_hs && in_last)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!v1 && !v2 && (out_cnt == npix)) begin
                        state   <= S_DONE;
                        ap_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    ap_idle <= 1'b1;
                end
                default: begin
                    state   <= S_IDLE;
                    ap_idle <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_normalizer.sv
// Directed bench for pixel_normalizer with a scoreboard fed from observed input handshakes.
module tb_pixel_normalizer;
    logic        clk = 1'b0;
    logic        reset;
    logic        ap_start;
    logic        upstream_done;
    logic [23:0] num_pixels;
    logic [8:0]  norm_coef;
    logic        ap_ready;
    logic        ap_idle;
    logic        ap_done;
    logic        sat_seen;
    logic        tlast_err;

    pixel_normalizer_if #(.DATA_W(10)) s_axis ();
    pixel_normalizer_if #(.DATA_W(10)) m_axis ();

    pixel_normalizer #(
        .PIXEL_W(10),
        .FRAC_W (8),
        .CNT_W  (24)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ap_start     (ap_start),
        .upstream_done(upstream_done),
        .num_pixels   (num_pixels),
        .norm_coef    (norm_coef),
        .ap_ready     (ap_ready),
        .ap_idle      (ap_idle),
        .ap_done      (ap_done),
        .sat_seen     (sat_seen),
        .tlast_err    (tlast_err),
        .s_axis       (s_axis),
        .m_axis       (m_axis)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        start_req;
    logic        rand_mode;
    logic [10:0] sb[$];
    int unsigned m_npix;
    int unsigned m_coef;
    int unsigned in_idx;
    int unsigned mval;
    logic        lst_b;
    logic        exp_sat;
    logic        exp_terr;
    int          beats;
    int          done_cnt;
    logic        prev_stall;
    logic [11:0] prev_word;
    logic [10:0] ent;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Output ready: held high or randomised each cycle
    initial begin
        m_axis.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis.tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Reference model and output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (start_req) begin
                m_npix   = num_pixels;
                m_coef   = norm_coef;
                in_idx   = 0;
                exp_sat  = 1'b0;
                exp_terr = 1'b0;
                beats    = 0;
                done_cnt = 0;
            end
            if (ap_done)
                done_cnt++;
            if (s_axis.tvalid && s_axis.tready) begin
                lst_b = (in_idx == m_npix - 1);
                mval  = (int'(s_axis.tdata) * m_coef + 128) >> 8;
                if (mval > 1023) begin
                    mval    = 1023;
                    exp_sat = 1'b1;
                end
                if (s_axis.tlast != lst_b)
                    exp_terr = 1'b1;
                sb.push_back({lst_b, mval[9:0]});
                in_idx++;
            end
            if (prev_stall)
                chk("stall_hold", {m_axis.tvalid, m_axis.tlast, m_axis.tdata}, prev_word);
            if (!m_axis.tvalid)
                chk("tdata_zero_when_idle", m_axis.tdata, 0);
            if (m_axis.tvalid && m_axis.tready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    ent = sb.pop_front();
                    chk("m_tdata", m_axis.tdata, ent[9:0]);
                    chk("m_tlast", m_axis.tlast, ent[10]);
                end
                beats++;
            end
            prev_stall = m_axis.tvalid && !m_axis.tready;
            prev_word  = {m_axis.tvalid, m_axis.tlast, m_axis.tdata};
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_frame(input int n, input int c, input bit up);
        ap_start      = 1'b1;
        start_req     = 1'b1;
        num_pixels    = 24'(n);
        norm_coef     = 9'(c);
        upstream_done = up;
        @(posedge clk);
        #1;
        ap_start      = 1'b0;
        start_req     = 1'b0;
        upstream_done = 1'b0;
        @(negedge clk);
        chk("ap_ready_pulse", ap_ready, 1);
        chk("ap_idle_low", ap_idle, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_pix(input int d, input bit last);
        int  n;
        bit  hs;
        n  = 0;
        hs = 1'b0;
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = 10'(d);
        s_axis.tlast  = last;
        while (!hs && n < 200) begin
            @(negedge clk);
            hs = s_axis.tready;
            n++;
        end
        if (!hs)
            chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
    endtask

    task automatic wait_done(input int exp_beats, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done_cnt != 0, 1);
        repeat (2) @(negedge clk);
        chk("done_once", done_cnt, 1);
        chk("idle_after_done", ap_idle, 1);
        chk("scoreboard_empty", sb.size(), 0);
        chk("beat_count", beats, exp_beats);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bad;
        reset         = 1'b1;
        ap_start      = 1'b0;
        start_req     = 1'b0;
        upstream_done = 1'b0;
        num_pixels    = '0;
        norm_coef     = '0;
        rand_mode     = 1'b0;
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = '0;
        s_axis.tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ap_idle", ap_idle, 1);
        chk("rst_ap_ready", ap_ready, 0);
        chk("rst_ap_done", ap_done, 0);
        chk("rst_s_tready", s_axis.tready, 0);
        chk("rst_m_tvalid", m_axis.tvalid, 0);
        chk("rst_m_tdata", m_axis.tdata, 0);
        chk("rst_m_tlast", m_axis.tlast, 0);
        chk("rst_flags", {sat_seen, tlast_err}, 0);
        @(posedge clk);
        #1;

        // Half gain, with a pending extra pixel that must not be taken
        start_frame(4, 'h080, 1'b1);
        send_pix(1000, 1'b0);
        send_pix(3, 1'b0);
        send_pix(1, 1'b0);
        send_pix(0, 1'b1);
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = 10'd5;
        wait_done(4, 100);
        chk("extra_not_taken", s_axis.tready, 0);
        s_axis.tvalid = 1'b0;
        chk("t1_sat_seen", sat_seen, exp_sat);
        chk("t1_tlast_err", tlast_err, 0);

        // Gain 1.5 with saturation
        start_frame(2, 'h180, 1'b1);
        send_pix(1000, 1'b0);
        send_pix(600, 1'b1);
        wait_done(2, 100);
        chk("t2_sat_seen", sat_seen, 1);
        chk("t2_sat_model", exp_sat, 1);

        // Upstream not done: no traffic, stray ap_start ignored
        start_frame(3, 'h100, 1'b0);
        ap_start = 1'b1;
        @(posedge clk);
        #1;
        ap_start = 1'b0;
        @(negedge clk);
        chk("busy_start_ignored", ap_ready, 0);
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = 10'd7;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_axis.tready || m_axis.tvalid)
                bad++;
        end
        chk("wait_up_blocked", bad, 0);
        @(posedge clk);
        #1;
        upstream_done = 1'b1;
        @(posedge clk);
        #1;
        upstream_done = 1'b0;
        send_pix(7, 1'b0);
        send_pix(200, 1'b0);
        send_pix(1023, 1'b1);
        wait_done(3, 100);

        // Unity gain, 256 pixels, random output back-pressure
        rand_mode = 1'b1;
        start_frame(256, 'h100, 1'b1);
        for (int i = 0; i < 256; i++)
            send_pix(int'($urandom_range(0, 1023)), i == 255);
        wait_done(256, 3000);
        rand_mode = 1'b0;
        chk("t4_tlast_err", tlast_err, 0);

        // Empty frame
        start_frame(0, 'h100, 1'b1);
        wait_done(0, 20);

        // Early upstream tlast
        start_frame(4, 'h100, 1'b1);
        send_pix(10, 1'b0);
        send_pix(20, 1'b1);
        send_pix(30, 1'b0);
        send_pix(40, 1'b0);
        wait_done(4, 100);
        chk("t5_tlast_err", tlast_err, 1);
        chk("t5_tlast_model", exp_terr, 1);

        // Reset in the middle of a frame, then a clean frame
        start_frame(8, 'h100, 1'b1);
        send_pix(11, 1'b0);
        send_pix(22, 1'b0);
        send_pix(33, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_ap_idle", ap_idle, 1);
        chk("midrst_m_tvalid", m_axis.tvalid, 0);
        chk("midrst_s_tready", s_axis.tready, 0);
        repeat (5) @(negedge clk);
        chk("midrst_no_done", done_cnt, 0);
        @(posedge clk);
        #1;
        start_frame(5, 'h0C0, 1'b0);
        upstream_done = 1'b1;
        @(posedge clk);
        #1;
        upstream_done = 1'b0;
        send_pix(100, 1'b0);
        send_pix(255, 1'b0);
        send_pix(1, 1'b0);
        send_pix(2, 1'b0);
        send_pix(1023, 1'b1);
        wait_done(5, 100);
        chk("t6_tlast_err", tlast_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
